// File: rtl/vcxo_tune_sequencer.sv
// VCXO tuning sequencer.
// Takes one signed frequency-error sample per gate period and moves the PWM
// tuning setpoint through the acquire, track and locked phases. It also
// detects lock and unlock, and faults when the setpoint keeps hitting a rail.
// Stage 1 registers the sample. Stage 2 makes the step/clamp/state decision.
module vcxo_tune_sequencer #(
    parameter int PWM_INIT    = 16000,
    parameter int PWM_MIN     = 1,
    parameter int PWM_MAX     = 32000,
    parameter int COARSE_THR  = 50,
    parameter int COARSE_STEP = 250,
    parameter int MID_THR     = 10,
    parameter int MID_STEP    = 50,
    parameter int STABLE_TOL  = 50,
    parameter int LOCK_COUNT  = 3,
    parameter int UNLOCK_THR  = 20,
    parameter int RAIL_LIMIT  = 8
) (
    input  logic        clk_in,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        meas_valid,
    input  logic [31:0] meas_error,
    output logic [23:0] pwm_setpoint,
    output logic        pwm_load,
    output logic        locked,
    output logic        fault,
    output logic [2:0]  seq_state
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACQUIRE = 3'd1,
        ST_TRACK   = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    localparam logic [23:0]        SP_INIT  = 24'(PWM_INIT);
    localparam logic signed [24:0] SP_MIN   = 25'(PWM_MIN);
    localparam logic signed [24:0] SP_MAX   = 25'(PWM_MAX);
    localparam logic [31:0]        COARSE_T = 32'(COARSE_THR);
    localparam logic [31:0]        MID_T    = 32'(MID_THR);
    localparam logic [31:0]        UNLOCK_T = 32'(UNLOCK_THR);
    localparam logic [32:0]        TOL      = 33'(STABLE_TOL);
    localparam logic [24:0]        COARSE_D = 25'(COARSE_STEP);
    localparam logic [24:0]        MID_D    = 25'(MID_STEP);
    localparam logic [24:0]        ONE_D    = 25'd1;
    localparam logic [3:0]         LOCK_N   = 4'(LOCK_COUNT);
    localparam logic [3:0]         RAIL_N   = 4'(RAIL_LIMIT);

    state_t      state_q, state_d;
    logic [23:0] sp_q, sp_d;
    logic        load_q, load_d;
    logic [31:0] prev_err_q, prev_err_d;
    logic        s1_valid_q, s1_valid_d;
    logic [31:0] err_q, err_d;
    logic [32:0] diff_q, diff_d;
    logic [31:0] abs_q, abs_d;
    logic [3:0]  lock_cnt_q, lock_cnt_d;
    logic [3:0]  rail_cnt_q, rail_cnt_d;

    logic [32:0]        abs_diff;
    logic               accepted;
    logic               err_zero;
    logic               err_neg;
    logic [24:0]        step_mag;
    logic signed [24:0] sp_raw;
    logic [23:0]        sp_sat;
    logic               clamped;
    logic               apply_step;

    // Stage-2 sample qualifiers: stability test and sign/zero of the error.
    always_comb begin
        abs_diff = diff_q[32] ? (33'd0 - diff_q) : diff_q;
        accepted = (abs_diff <= TOL);
        err_zero = (err_q == 32'd0);
        err_neg  = err_q[31];
    end

    // Candidate step for the current phase, then saturate it to the PWM rails.
    always_comb begin
        step_mag = 25'd0;
        if (!err_zero) begin
            if (state_q == ST_ACQUIRE && abs_q > COARSE_T) begin
                step_mag = COARSE_D;
            end else if (state_q != ST_LOCKED && abs_q > MID_T) begin
                step_mag = MID_D;
            end else begin
                step_mag = ONE_D;
            end
        end
        // A negative error means the oscillator is slow, so raise the setpoint.
        sp_raw  = $signed({1'b0, sp_q}) + (err_neg ? $signed(step_mag) : -$signed(step_mag));
        clamped = 1'b0;
        sp_sat  = sp_raw[23:0];
        if (sp_raw < SP_MIN) begin
            sp_sat  = SP_MIN[23:0];
            clamped = 1'b1;
        end else if (sp_raw > SP_MAX) begin
            sp_sat  = SP_MAX[23:0];
            clamped = 1'b1;
        end
    end

    // Next-state logic: sample capture, phase decisions and the enable-low flush.
    always_comb begin
        state_d    = state_q;
        sp_d       = sp_q;
        load_d     = 1'b0;
        prev_err_d = prev_err_q;
        s1_valid_d = 1'b0;
        err_d      = err_q;
        diff_d     = diff_q;
        abs_d      = abs_q;
        lock_cnt_d = lock_cnt_q;
        rail_cnt_d = rail_cnt_q;
        apply_step = 1'b0;

        // A strobe that arrives while stage 1 is occupied is dropped.
        if (!s1_valid_q && meas_valid &&
            (state_q == ST_ACQUIRE || state_q == ST_TRACK || state_q == ST_LOCKED)) begin
            s1_valid_d = 1'b1;
            err_d      = meas_error;
            diff_d     = {prev_err_q[31], prev_err_q} - {meas_error[31], meas_error};
            abs_d      = meas_error[31] ? (32'd0 - meas_error) : meas_error;
            prev_err_d = meas_error;
        end

        case (state_q)
            ST_IDLE: begin
                // A reinit deferred behind a previous load strobe finishes here first.
                if (sp_q != SP_INIT) begin
                    if (!load_q) begin
                        sp_d   = SP_INIT;
                        load_d = 1'b1;
                    end
                end else begin
                    state_d    = ST_ACQUIRE;
                    prev_err_d = 32'd0;
                end
            end
            ST_ACQUIRE: begin
                if (s1_valid_q) begin
                    if (!accepted) begin
                        lock_cnt_d = 4'd0;
                    end else if (abs_q > COARSE_T) begin
                        apply_step = 1'b1;
                        if (clamped) begin
                            rail_cnt_d = rail_cnt_q + 4'd1;
                            if (rail_cnt_q + 4'd1 == RAIL_N) begin
                                state_d = ST_FAULT;
                            end
                        end else begin
                            rail_cnt_d = 4'd0;
                        end
                    end else begin
                        // Close enough: hand over to TRACK and apply its step now.
                        state_d    = ST_TRACK;
                        rail_cnt_d = 4'd0;
                        apply_step = 1'b1;
                        if (err_zero) begin
                            lock_cnt_d = lock_cnt_q + 4'd1;
                            if (lock_cnt_q + 4'd1 == LOCK_N) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            lock_cnt_d = 4'd0;
                        end
                    end
                end
            end
            ST_TRACK: begin
                if (s1_valid_q) begin
                    if (!accepted) begin
                        lock_cnt_d = 4'd0;
                    end else if (abs_q > COARSE_T) begin
                        state_d    = ST_ACQUIRE;
                        lock_cnt_d = 4'd0;
                    end else begin
                        apply_step = 1'b1;
                        if (err_zero) begin
                            lock_cnt_d = lock_cnt_q + 4'd1;
                            if (lock_cnt_q + 4'd1 == LOCK_N) begin
                                state_d = ST_LOCKED;
                            end
                        end else begin
                            lock_cnt_d = 4'd0;
                        end
                    end
                end
            end
            ST_LOCKED: begin
                if (s1_valid_q) begin
                    if (!accepted) begin
                        lock_cnt_d = 4'd0;
                    end else if (abs_q > UNLOCK_T) begin
                        state_d    = ST_TRACK;
                        lock_cnt_d = 4'd0;
                    end else begin
                        apply_step = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (apply_step) begin
            sp_d   = sp_sat;
            load_d = (sp_sat != sp_q);
        end

        // Enable low wins over everything: flush the pipeline and reinitialise.
        if (!enable) begin
            state_d    = ST_IDLE;
            s1_valid_d = 1'b0;
            lock_cnt_d = 4'd0;
            rail_cnt_d = 4'd0;
            prev_err_d = 32'd0;
            sp_d       = sp_q;
            load_d     = 1'b0;
            if (sp_q != SP_INIT && !load_q) begin
                sp_d   = SP_INIT;
                load_d = 1'b1;
            end
        end
    end

    // State and pipeline registers.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            sp_q       <= SP_INIT;
            load_q     <= 1'b0;
            prev_err_q <= 32'd0;
            s1_valid_q <= 1'b0;
            err_q      <= 32'd0;
            diff_q     <= 33'd0;
            abs_q      <= 32'd0;
            lock_cnt_q <= 4'd0;
            rail_cnt_q <= 4'd0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            load_q     <= load_d;
            prev_err_q <= prev_err_d;
            s1_valid_q <= s1_valid_d;
            err_q      <= err_d;
            diff_q     <= diff_d;
            abs_q      <= abs_d;
            lock_cnt_q <= lock_cnt_d;
            rail_cnt_q <= rail_cnt_d;
        end
    end

    assign pwm_setpoint = sp_q;
    assign pwm_load     = load_q;
    assign locked       = (state_q == ST_LOCKED);
    assign fault        = (state_q == ST_FAULT);
    assign seq_state    = state_q;

endmodule

// File: tb/tb_vcxo_tune_sequencer.sv
// Bench for vcxo_tune_sequencer.
// Directed scenarios are followed by randomized samples. Every expected value
// comes from a transaction-level model of the sequencing rules.
module tb_vcxo_tune_sequencer;

    logic        clk_in = 1'b0;
    logic        reset_n;
    logic        enable;
    logic        meas_valid;
    logic [31:0] meas_error;
    logic [23:0] pwm_setpoint;
    logic        pwm_load;
    logic        locked;
    logic        fault;
    logic [2:0]  seq_state;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state. State numbers use the seq_state encoding 0..4.
    int     m_state;
    longint m_sp;
    longint m_prev;
    int     m_lock;
    int     m_rail;
    logic   m_load;

    int dir_tab [21] = '{-300, -300, -300, -300, -260, -220, -180, -140, -100, -60,
                         -30, -5, 0, 0, 0, 15, 25, 0, -400, -380, -380};

    always #5 clk_in = ~clk_in;

    vcxo_tune_sequencer dut (
        .clk_in       (clk_in),
        .reset_n      (reset_n),
        .enable       (enable),
        .meas_valid   (meas_valid),
        .meas_error   (meas_error),
        .pwm_setpoint (pwm_setpoint),
        .pwm_load     (pwm_load),
        .locked       (locked),
        .fault        (fault),
        .seq_state    (seq_state)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_sp"},     32'(pwm_setpoint), 32'(m_sp));
        chk({tag, "_load"},   32'(pwm_load),     32'(m_load));
        chk({tag, "_state"},  32'(seq_state),    32'(m_state));
        chk({tag, "_locked"}, 32'(locked),       32'(m_state == 3));
        chk({tag, "_fault"},  32'(fault),        32'(m_state == 4));
    endtask

    // TRACK-phase step size and lock bookkeeping for a stable, small error.
    task automatic model_track(input longint e, input longint a, output longint mag);
        if (e == 0) begin
            mag = 0;
            m_lock++;
            if (m_lock == 3) m_state = 3;
        end else begin
            mag    = (a > 10) ? 50 : 1;
            m_lock = 0;
        end
    endtask

    // One processed sample: rules applied directly with integer arithmetic.
    task automatic model_sample(input logic [31:0] raw);
        longint e, d, a, mag, nsp;
        bit     step, coarse, clamped;
        e      = longint'($signed(raw));
        m_load = 1'b0;
        if (m_state == 0 || m_state == 4) return;
        d      = m_prev - e;
        m_prev = e;
        a      = (e < 0) ? -e : e;
        mag    = 0;
        step   = 0;
        coarse = 0;
        if (d > 50 || d < -50) begin
            m_lock = 0;
        end else if (m_state == 1) begin
            if (a > 50) begin
                mag = 250; step = 1; coarse = 1;
            end else begin
                m_state = 2; m_rail = 0; step = 1;
                model_track(e, a, mag);
            end
        end else if (m_state == 2) begin
            if (a > 50) begin
                m_state = 1; m_lock = 0;
            end else begin
                step = 1;
                model_track(e, a, mag);
            end
        end else begin
            if (a > 20) begin
                m_state = 2; m_lock = 0;
            end else begin
                step = 1;
                mag  = (e == 0) ? 0 : 1;
            end
        end
        if (step) begin
            nsp     = (e < 0) ? m_sp + mag : m_sp - mag;
            clamped = 0;
            if (nsp > 32000) begin nsp = 32000; clamped = 1; end
            else if (nsp < 1) begin nsp = 1; clamped = 1; end
            if (coarse) begin
                m_rail = clamped ? m_rail + 1 : 0;
                if (m_rail == 8) m_state = 4;
            end
            m_load = (nsp != m_sp);
            m_sp   = nsp;
        end
    endtask

    task automatic model_disable();
        m_load  = (m_sp != 16000);
        m_sp    = 16000;
        m_state = 0;
        m_lock  = 0;
        m_rail  = 0;
        m_prev  = 0;
    endtask

    task automatic model_enable();
        m_state = 1;
        m_prev  = 0;
        m_load  = 1'b0;
    endtask

    // One strobe; result checked at N+2, load strobe checked low at N+3.
    task automatic send(input logic [31:0] e, input string tag);
        meas_valid = 1'b1;
        meas_error = e;
        @(posedge clk_in); #1;
        meas_valid = 1'b0;
        meas_error = $urandom();
        @(posedge clk_in); #1;
        model_sample(e);
        check_all(tag);
        @(posedge clk_in); #1;
        chk({tag, "_load_low"}, 32'(pwm_load), 32'd0);
    endtask

    // Two strobes on consecutive cycles: the second lands in the stage-1 cycle.
    task automatic send_pair(input logic [31:0] e1, input logic [31:0] e2, input string tag);
        meas_valid = 1'b1;
        meas_error = e1;
        @(posedge clk_in); #1;
        meas_error = e2;
        @(posedge clk_in); #1;
        meas_valid = 1'b0;
        model_sample(e1);
        check_all(tag);
        @(posedge clk_in); #1;
        chk({tag, "_load_low"}, 32'(pwm_load), 32'd0);
        chk({tag, "_hold1"}, 32'(pwm_setpoint), 32'(m_sp));
        @(posedge clk_in); #1;
        chk({tag, "_hold2"}, 32'(pwm_setpoint), 32'(m_sp));
        chk({tag, "_state2"}, 32'(seq_state), 32'(m_state));
    endtask

    // Drop enable for one cycle, optionally with a coincident strobe, then re-enable.
    task automatic drop_enable(input string tag, input bit strobe);
        enable     = 1'b0;
        meas_valid = strobe;
        meas_error = $urandom();
        @(posedge clk_in); #1;
        meas_valid = 1'b0;
        model_disable();
        check_all({tag, "_off"});
        enable = 1'b1;
        @(posedge clk_in); #1;
        model_enable();
        check_all({tag, "_on"});
    endtask

    function automatic logic [31:0] rand_err();
        int     r;
        longint v;
        r = int'($urandom_range(0, 99));
        if (r < 30)      v = 0;
        else if (r < 60) v = longint'(int'($urandom_range(0, 50)) - 25);
        else if (r < 85) v = m_prev + longint'(int'($urandom_range(0, 120)) - 60);
        else if (r < 95) v = longint'(int'($urandom_range(0, 4000)) - 2000);
        else             return $urandom();
        return 32'(v);
    endfunction

    initial begin
        int k;
        reset_n    = 1'b0;
        enable     = 1'b0;
        meas_valid = 1'b0;
        meas_error = 32'd0;
        m_state = 0; m_sp = 16000; m_prev = 0; m_lock = 0; m_rail = 0; m_load = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check_all("reset");
        reset_n = 1'b1;
        @(posedge clk_in); #1;
        check_all("idle");
        enable = 1'b1;
        @(posedge clk_in); #1;
        model_enable();
        check_all("enable");

        // Acquire ramp, hand-over to track, lock, small locked step, unlock,
        // then a rejected jump followed by re-acquire.
        for (int i = 0; i < 21; i++) begin
            send(32'(dir_tab[i]), $sformatf("dir%0d", i));
        end

        // Drive into the upper rail until the fault trips, plus one ignored sample.
        drop_enable("rail_pre", 1'b0);
        k = 0;
        while (m_state != 4 && k < 100) begin
            send(32'(-1000), $sformatf("rail%0d", k));
            k++;
        end
        send(32'(-1000), "rail_after_fault");

        // Enable falls during the stage-1 cycle: the sample must be discarded.
        drop_enable("t6_pre", 1'b0);
        send(32'(-20), "t6_move");
        meas_valid = 1'b1;
        meas_error = 32'(-20);
        @(posedge clk_in); #1;
        meas_valid = 1'b0;
        enable     = 1'b0;
        @(posedge clk_in); #1;
        model_disable();
        check_all("t6_off");
        @(posedge clk_in); #1;
        chk("t6_load_low", 32'(pwm_load), 32'd0);
        chk("t6_idle_sp", 32'(pwm_setpoint), 32'd16000);
        enable = 1'b1;
        @(posedge clk_in); #1;
        model_enable();
        check_all("t6_on");

        // Back-to-back strobes: the second is dropped.
        send_pair(32'(-40), 32'(-45), "b2b");
        send(32'(-40), "b2b_next");

        // Randomized traffic.
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 99));
            if (r < 5) begin
                drop_enable($sformatf("rdis%0d", i), 1'($urandom_range(0, 1)));
            end else if (r < 10) begin
                send_pair(rand_err(), $urandom(), $sformatf("rpair%0d", i));
            end else begin
                send(rand_err(), $sformatf("rnd%0d", i));
            end
        end

        // Asynchronous reset mid-operation, checked before any clock edge.
        send(32'(m_prev - 30), "pre_reset");
        #2;
        reset_n = 1'b0;
        #1;
        m_state = 0; m_sp = 16000; m_prev = 0; m_lock = 0; m_rail = 0; m_load = 1'b0;
        check_all("async_reset");
        @(posedge clk_in); #1;
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
